npc_btb: RTL

Parametrised next-PC generator with an integrated branch target buffer (BTB) and 2-bit saturating direction predictors, for the pipelined MIPS datapath. It holds the fetch PC register and predicts the next fetch address each cycle from the BTB. It accepts redirects from the execute stage and trains the BTB with resolved branch and jump outcomes. It takes over from the combinational next-PC selector used in the single-cycle core.

---
 rtl/npc_btb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/npc_btb.sv
// npc_btb -- fetch PC register with a direct-mapped branch target buffer.
//
// Each cycle the current fetch address PC indexes the BTB combinationally.
// A valid entry whose tag matches supplies a predicted target. The entry's
// 2-bit saturating counter decides whether that target is used; an entry
// marked unconditional always uses it. The execute stage can redirect the
// fetch stream, and it trains the BTB with resolved outcomes.
//
// Parameters
//   RESET_PC   fetch address loaded on reset
//   BTB_DEPTH  number of BTB entries (power of two, >= 2)
//   IDX_W      index width, derived from BTB_DEPTH
//   TAG_W      tag width, PC[31:IDX_W+2]
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   stall              hold PC for one cycle
//   redirect           load redirect_pc; this wins over stall
//   redirect_pc        corrected fetch address
//   upd_valid          a resolved control-flow instruction is present
//   upd_pc             address of the resolved instruction
//   upd_taken          actual direction
//   upd_uncond         the resolved instruction is an unconditional jump
//   upd_target         actual target address
//   PC                 registered fetch address
//   pred_taken         prediction for PC, combinational from BTB state
//   pred_target        predicted next fetch address (PC+4 when not taken)
module npc_btb #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          BTB_DEPTH = 16,
  parameter int          IDX_W     = $clog2(BTB_DEPTH),
  parameter int          TAG_W     = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_uncond,
  input  logic [31:0] upd_target,
  output logic [31:0] PC,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  // Per-entry state is held inside the generate loop. These arrays are the
  // read-side view of that state.
  logic             valid_arr  [BTB_DEPTH];
  logic [TAG_W-1:0] tag_arr    [BTB_DEPTH];
  logic [29:0]      target_arr [BTB_DEPTH];
  logic [1:0]       ctr_arr    [BTB_DEPTH];
  logic             uncond_arr [BTB_DEPTH];

  logic [31:0]      pc_reg;
  logic [31:0]      pc_next;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr_next;

  // Word-offset bits of the update addresses carry no information.
  logic             unused_low_bits;
  assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

  // ---------------- lookup ----------------
  assign rd_idx = pc_reg[IDX_W+1:2];
  assign rd_tag = pc_reg[31:IDX_W+2];
  assign rd_hit = valid_arr[rd_idx] && (tag_arr[rd_idx] == rd_tag);

  assign pred_taken  = rd_hit && (uncond_arr[rd_idx] || ctr_arr[rd_idx][1]);
  assign pred_target = pred_taken ? {target_arr[rd_idx], 2'b00} : (pc_reg + 32'd4);
  assign PC          = pc_reg;

  // ---------------- PC register ----------------
  always_comb begin
    pc_next = pred_target;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (stall) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // ---------------- training ----------------
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign upd_hit = valid_arr[upd_idx] && (tag_arr[upd_idx] == upd_tag);

  // Saturating step of the indexed counter toward the resolved direction.
  always_comb begin
    upd_ctr_next = ctr_arr[upd_idx];
    if (upd_taken) begin
      if (ctr_arr[upd_idx] != 2'b11) upd_ctr_next = ctr_arr[upd_idx] + 2'b01;
    end else begin
      if (ctr_arr[upd_idx] != 2'b00) upd_ctr_next = ctr_arr[upd_idx] - 2'b01;
    end
  end

  for (genvar gi = 0; gi < BTB_DEPTH; gi++) begin : g_entry
    logic             valid_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [29:0]      target_reg;
    logic [1:0]       ctr_reg;
    logic             uncond_reg;
    logic             sel;

    assign sel = upd_valid && (upd_idx == IDX_W'(gi));

    // Tag, target and uncond are not reset. They are only observed once
    // valid is set, and allocation writes all three.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        ctr_reg   <= 2'b01;
      end else if (sel) begin
        if (upd_hit) begin
          if (upd_uncond) begin
            target_reg <= upd_target[31:2];
            uncond_reg <= 1'b1;
          end else begin
            ctr_reg <= upd_ctr_next;
            if (upd_taken) target_reg <= upd_target[31:2];
          end
        end else if (upd_taken) begin
          // A taken miss replaces whatever occupied the slot (direct-mapped).
          valid_reg  <= 1'b1;
          tag_reg    <= upd_tag;
          target_reg <= upd_target[31:2];
          uncond_reg <= upd_uncond;
          ctr_reg    <= 2'b10;
        end
      end
    end

    assign valid_arr[gi]  = valid_reg;
    assign tag_arr[gi]    = tag_reg;
    assign target_arr[gi] = target_reg;
    assign ctr_arr[gi]    = ctr_reg;
    assign uncond_arr[gi] = uncond_reg;
  end

endmodule
